kf6845_crt_timing_generator: RTL and testbench
==============================================

// Module: kf6845_crt_timing_generator
// PURPOSE
//  Horizontal/vertical raster timing core of the KF6845 CRTC. Holds R0,R1,R4,R5,R6,R9, runs char/raster/row counters
//  on video_clock_enable, and emits the one-clock strobes Horizontal, Horizontal_End, Scanline_End, V_total consumed
//  directly by the linear address generator (MA) downstream; also drives RA and display windows toward the video path.
// PARAMETERS
//  H_TOTAL_INIT      8'd10  R0 reset value (char clocks per line minus 1)
//  H_DISPLAYED_INIT  8'd5   R1 reset value (displayed chars per line)
//  V_TOTAL_INIT      7'd5   R4 reset value (char rows per frame minus 1)
//  V_ADJUST_INIT     5'd0   R5 reset value (extra scanlines after last row)
//  V_DISPLAYED_INIT  7'd5   R6 reset value (displayed char rows)
//  MAX_SCAN_INIT     5'd3   R9 reset value (scanlines per row minus 1)
// PORTS
//  clock                                input   1  system clock, all state on rising edge
//  reset_n                              input   1  synchronous reset, active low
//  video_clock_enable                   input   1  character clock enable, counters advance only when 1
//  internal_data_bus                    input   8  register write data
//  write_horizontal_total_register      input   1  load R0 <= data[7:0]
//  write_horizontal_displayed_register  input   1  load R1 <= data[7:0]
//  write_vertical_total_register        input   1  load R4 <= data[6:0]
//  write_vertical_total_adjust_register input   1  load R5 <= data[4:0]
//  write_vertical_displayed_register    input   1  load R6 <= data[6:0]
//  write_maximum_scan_line_register     input   1  load R9 <= data[4:0]
//  Horizontal                           output  1  strobe: last char clock of line (h_count==R0)
//  Horizontal_End                       output  1  strobe: end of displayed part (h_count==R1)
//  Scanline_End                         output  1  strobe: Horizontal on last scanline of a row (RA==R9)
//  V_total                              output  1  strobe: Horizontal on last scanline of frame
//  RA                                   output  5  raster address within current row
//  horizontal_display                   output  1  1 while h_count < R1
//  vertical_display                     output  1  1 while row_count < R6 and not in adjust
//  display_enable                       output  1  see CONFIGURATION
// BEHAVIOUR
//  - Reset (reset_n==0 at clock edge): h_count=0, RA=0, row_count=0, state=ROWS, R* = *_INIT; all strobes 0 while
//    reset_n==0; horizontal_display=vertical_display=display_enable=0 until first enabled char clock.
//  - Register writes: independent of video_clock_enable; new value used from next clock. Compares in the write cycle
//    use old value. Simultaneous writes to different registers all take effect.
//  - Strobes: combinational decode of registered counters AND video_clock_enable -> exactly one clock wide, zero latency.
//  - h_count (8b): on enable, ==R0 -> 0, else +1 (wraps 255->0 if R0 rewritten below current count; no Horizontal
//    until match).
//  - RA (5b), on Horizontal: state ROWS: RA==R9 -> RA=0, row_count+1 (Scanline_End); else RA+1.
//  - FSM ROWS: Scanline_End with row_count==R4: R5==0 -> V_total, row_count=0, RA=0, stay ROWS; R5!=0 -> ADJUST,
//    RA=0, adj_count=0, no V_total.
//  - FSM ADJUST: on Horizontal adj_count+1; adj_count==R5-1 -> V_total, row_count=0, RA=0, -> ROWS. RA held 0 and
//    Scanline_End suppressed in ADJUST.
//  - row_count (7b) wraps 127->0 if R4 rewritten below it; V_total only on exact match.
//  - V_total and Scanline_End coincide at frame end when R5==0 (downstream MA reload takes priority there).
//  - horizontal_display/vertical_display registered, update on enabled char clocks; R1==0 or R6==0 -> always 0.
// CONFIGURATION
//  - KF6845_DISPLAY_ENABLE_EN defined: display_enable = registered (horizontal_display & vertical_display), one
//    enabled char clock after the window terms (aligns with MA pipeline).
//  - Not defined: display_enable tied 0; window outputs unchanged.
// TESTING
//  1. Defaults, enable toggling every clock -> Horizontal every 22 clocks, Horizontal_End 12 clocks after each line
//     start (h_count 5), Scanline_End every 4th Horizontal, V_total every 24th Horizontal.
//  2. Write R5=2 -> V_total every 26th Horizontal; RA stays 0 for 2 adjust lines; no Scanline_End in them.
//  3. Write R0=3 while h_count==7 -> h_count runs to 255, wraps, next Horizontal at h_count==3; later lines 4 chars.
//  4. Write R6=2, R1=4 -> vertical_display low for rows 2..5; horizontal_display high for h_count 0..3 only.
//  5. Assert reset_n=0 mid-row (RA=2,row=3) one clock -> all counters 0, R* back to INIT, strobes 0 during reset.
//  6. With KF6845_DISPLAY_ENABLE_EN -> display_enable = AND of windows delayed one enabled clock; without -> always 0.

Source files
------------

// File: rtl/kf6845_crt_timing_generator.sv
// KF6845 CRTC raster timing core: R0/R1/R4/R5/R6/R9, char/scanline/row counters and line/frame strobes.
// Define KF6845_DISPLAY_ENABLE_EN to get a registered display_enable; otherwise it is tied low.
module kf6845_crt_timing_generator #(
    parameter logic [7:0] H_TOTAL_INIT     = 8'd10,
    parameter logic [7:0] H_DISPLAYED_INIT = 8'd5,
    parameter logic [6:0] V_TOTAL_INIT     = 7'd5,
    parameter logic [4:0] V_ADJUST_INIT    = 5'd0,
    parameter logic [6:0] V_DISPLAYED_INIT = 7'd5,
    parameter logic [4:0] MAX_SCAN_INIT    = 5'd3
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       video_clock_enable,
    input  logic [7:0] internal_data_bus,
    input  logic       write_horizontal_total_register,
    input  logic       write_horizontal_displayed_register,
    input  logic       write_vertical_total_register,
    input  logic       write_vertical_total_adjust_register,
    input  logic       write_vertical_displayed_register,
    input  logic       write_maximum_scan_line_register,
    output logic       Horizontal,
    output logic       Horizontal_End,
    output logic       Scanline_End,
    output logic       V_total,
    output logic [4:0] RA,
    output logic       horizontal_display,
    output logic       vertical_display,
    output logic       display_enable
);

    typedef enum logic [0:0] {
        ROWS   = 1'b0,
        ADJUST = 1'b1
    } frame_state_t;

    frame_state_t state_q;
    frame_state_t state_next;

    logic [7:0] r0_h_total;
    logic [7:0] r1_h_displayed;
    logic [6:0] r4_v_total;
    logic [4:0] r5_v_adjust;
    logic [6:0] r6_v_displayed;
    logic [4:0] r9_max_scan;

    logic [7:0] h_count;
    logic [4:0] ra_count;
    logic [6:0] row_count;
    logic [4:0] adj_count;

    logic [7:0] h_next;
    logic [4:0] ra_next;
    logic [6:0] row_next;
    logic [4:0] adj_next;

    logic       h_match;
    logic       hend_match;
    logic       last_scan;
    logic       last_row;
    logic       adj_last;
    logic       strobe_ok;

    logic       h_window_p0;
    logic       v_window_p0;
    logic       h_window_next;
    logic       v_window_next;

    // Strobes decode the registered counters; gating by enable makes them one clock wide.
    always_comb begin
        h_match        = (h_count == r0_h_total);
        hend_match     = (h_count == r1_h_displayed);
        last_scan      = (ra_count == r9_max_scan);
        last_row       = (row_count == r4_v_total);
        adj_last       = (adj_count == (r5_v_adjust - 5'd1));
        strobe_ok      = video_clock_enable & reset_n;
        Horizontal     = strobe_ok & h_match;
        Horizontal_End = strobe_ok & hend_match;
        Scanline_End   = Horizontal & (state_q == ROWS) & last_scan;
        V_total        = Horizontal &
                         (((state_q == ROWS) & last_scan & last_row & (r5_v_adjust == 5'd0)) |
                          ((state_q == ADJUST) & adj_last));
    end

    always_comb begin
        state_next = state_q;
        h_next     = h_match ? 8'd0 : h_count + 8'd1;
        ra_next    = ra_count;
        row_next   = row_count;
        adj_next   = adj_count;
        if (h_match) begin
            case (state_q)
                ROWS: begin
                    if (last_scan) begin
                        ra_next = 5'd0;
                        if (last_row) begin
                            if (r5_v_adjust == 5'd0) begin
                                row_next = 7'd0;
                            end else begin
                                state_next = ADJUST;
                                adj_next   = 5'd0;
                            end
                        end else begin
                            row_next = row_count + 7'd1;
                        end
                    end else begin
                        ra_next = ra_count + 5'd1;
                    end
                end
                ADJUST: begin
                    ra_next = 5'd0;
                    if (adj_last) begin
                        state_next = ROWS;
                        row_next   = 7'd0;
                        adj_next   = 5'd0;
                    end else begin
                        adj_next = adj_count + 5'd1;
                    end
                end
                default: state_next = ROWS;
            endcase
        end
        // Windows are computed from the post-update counters so they line up with h_count/row_count.
        h_window_next = (h_next < r1_h_displayed);
        v_window_next = (row_next < r6_v_displayed) && (state_next == ROWS);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= ROWS;
            h_count   <= 8'd0;
            ra_count  <= 5'd0;
            row_count <= 7'd0;
            adj_count <= 5'd0;
        end else if (video_clock_enable) begin
            h_count <= h_next;
            if (h_match) begin
                state_q   <= state_next;
                ra_count  <= ra_next;
                row_count <= row_next;
                adj_count <= adj_next;
            end
        end
    end

    // Window stage: registered on enabled char clocks only.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            h_window_p0 <= 1'b0;
            v_window_p0 <= 1'b0;
        end else if (video_clock_enable) begin
            h_window_p0 <= h_window_next;
            v_window_p0 <= v_window_next;
        end
    end

    // Register writes ignore the char clock enable; compares this cycle still see the old value.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r0_h_total     <= H_TOTAL_INIT;
            r1_h_displayed <= H_DISPLAYED_INIT;
            r4_v_total     <= V_TOTAL_INIT;
            r5_v_adjust    <= V_ADJUST_INIT;
            r6_v_displayed <= V_DISPLAYED_INIT;
            r9_max_scan    <= MAX_SCAN_INIT;
        end else begin
            if (write_horizontal_total_register)      r0_h_total     <= internal_data_bus;
            if (write_horizontal_displayed_register)  r1_h_displayed <= internal_data_bus;
            if (write_vertical_total_register)        r4_v_total     <= internal_data_bus[6:0];
            if (write_vertical_total_adjust_register) r5_v_adjust    <= internal_data_bus[4:0];
            if (write_vertical_displayed_register)    r6_v_displayed <= internal_data_bus[6:0];
            if (write_maximum_scan_line_register)     r9_max_scan    <= internal_data_bus[4:0];
        end
    end

    assign RA                 = ra_count;
    assign horizontal_display = h_window_p0;
    assign vertical_display   = v_window_p0;

`ifdef KF6845_DISPLAY_ENABLE_EN
    logic de_p1;

    // Display-enable stage: one enabled char clock behind the windows, matching the MA pipeline.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            de_p1 <= 1'b0;
        end else if (video_clock_enable) begin
            de_p1 <= h_window_p0 & v_window_p0;
        end
    end

    assign display_enable = de_p1;
`else
    assign display_enable = 1'b0;
`endif

endmodule

// File: tb/tb_kf6845_crt_timing_generator.sv
// Testbench for kf6845_crt_timing_generator: vector table, hand sequences and a line/frame reference model.
module tb_kf6845_crt_timing_generator;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       video_clock_enable;
    logic [7:0] internal_data_bus;
    logic       write_horizontal_total_register;
    logic       write_horizontal_displayed_register;
    logic       write_vertical_total_register;
    logic       write_vertical_total_adjust_register;
    logic       write_vertical_displayed_register;
    logic       write_maximum_scan_line_register;
    logic       Horizontal;
    logic       Horizontal_End;
    logic       Scanline_End;
    logic       V_total;
    logic [4:0] RA;
    logic       horizontal_display;
    logic       vertical_display;
    logic       display_enable;

    localparam int W_R0 = 0;
    localparam int W_R1 = 1;
    localparam int W_R4 = 2;
    localparam int W_R5 = 3;
    localparam int W_R6 = 4;
    localparam int W_R9 = 5;

    int checks = 0;
    int errors = 0;

    // reference model state: char position in line and line index within frame
    int m_r0, m_r1, m_r4, m_r5, m_r6, m_r9;
    int m_h, m_line;
    bit m_hd, m_vd, m_de;

    typedef struct {
        logic        rn;
        logic        ce;
        logic [5:0]  wr;
        logic [7:0]  d;
        logic [10:0] exp;  // {H, HE, SE, VT, RA[4:0], hd, vd}
    } vec_t;

    vec_t vecs[15];

    kf6845_crt_timing_generator dut (
        .clock                                (clock),
        .reset_n                              (reset_n),
        .video_clock_enable                   (video_clock_enable),
        .internal_data_bus                    (internal_data_bus),
        .write_horizontal_total_register      (write_horizontal_total_register),
        .write_horizontal_displayed_register  (write_horizontal_displayed_register),
        .write_vertical_total_register        (write_vertical_total_register),
        .write_vertical_total_adjust_register (write_vertical_total_adjust_register),
        .write_vertical_displayed_register    (write_vertical_displayed_register),
        .write_maximum_scan_line_register     (write_maximum_scan_line_register),
        .Horizontal                           (Horizontal),
        .Horizontal_End                       (Horizontal_End),
        .Scanline_End                         (Scanline_End),
        .V_total                              (V_total),
        .RA                                   (RA),
        .horizontal_display                   (horizontal_display),
        .vertical_display                     (vertical_display),
        .display_enable                       (display_enable)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rn, input logic ce, input logic [5:0] wr, input logic [7:0] d);
        @(negedge clock);
        reset_n                              = rn;
        video_clock_enable                   = ce;
        write_horizontal_total_register      = wr[0];
        write_horizontal_displayed_register  = wr[1];
        write_vertical_total_register        = wr[2];
        write_vertical_total_adjust_register = wr[3];
        write_vertical_displayed_register    = wr[4];
        write_maximum_scan_line_register     = wr[5];
        internal_data_bus                    = d;
        #1;
    endtask

    task automatic write_reg(input int idx, input logic [7:0] val);
        logic [5:0] wr;
        wr = 6'd0;
        wr[idx] = 1'b1;
        drive(1'b1, 1'b0, wr, val);
    endtask

    task automatic model_reset();
        m_r0 = 10; m_r1 = 5; m_r4 = 5; m_r5 = 0; m_r6 = 5; m_r9 = 3;
        m_h = 0; m_line = 0;
        m_hd = 1'b0; m_vd = 1'b0; m_de = 1'b0;
    endtask

    // Frame = (R4+1)*(R9+1) text lines followed by R5 adjust lines; every output follows from (m_h, m_line).
    task automatic run_model(input int ncyc, input bit rand_ce);
        int          rows, frame;
        logic        ce, e_h, e_he, e_se, e_vt, e_de;
        logic [4:0]  e_ra;
        logic [11:0] exp_v, act_v;
        for (int c = 0; c < ncyc; c++) begin
            ce = rand_ce ? ($urandom_range(0, 3) != 0) : 1'b1;
            drive(1'b1, ce, 6'd0, 8'd0);
            rows  = (m_r4 + 1) * (m_r9 + 1);
            frame = rows + m_r5;
            e_h   = ce && (m_h == m_r0);
            e_he  = ce && (m_h == m_r1);
            e_se  = e_h && (m_line < rows) && ((m_line % (m_r9 + 1)) == m_r9);
            e_vt  = e_h && (m_line == frame - 1);
            e_ra  = (m_line < rows) ? 5'(m_line % (m_r9 + 1)) : 5'd0;
`ifdef KF6845_DISPLAY_ENABLE_EN
            e_de  = m_de;
`else
            e_de  = 1'b0;
`endif
            exp_v = {e_h, e_he, e_se, e_vt, e_ra, m_hd, m_vd, e_de};
            act_v = {Horizontal, Horizontal_End, Scanline_End, V_total, RA,
                     horizontal_display, vertical_display, display_enable};
            check("model_outputs", int'(act_v), int'(exp_v));
            if (ce) begin
                m_de = m_hd && m_vd;
                if (m_h == m_r0) begin
                    m_h    = 0;
                    m_line = (m_line + 1) % frame;
                end else begin
                    m_h = (m_h + 1) % 256;
                end
                m_hd = (m_h < m_r1);
                m_vd = (m_line < rows) && ((m_line / (m_r9 + 1)) < m_r6);
            end
        end
    endtask

    // Default geometry (11 chars, 4 scanlines, 6 rows) plus adj extra lines; checks strobe timing per line.
    task automatic line_events(input bit toggle, input int adj, input int ncyc);
        int period, first_h, first_he, he_gap, k, last_h, kk, exp_n, fl;
        period   = toggle ? 22 : 11;
        first_h  = toggle ? 20 : 10;
        first_he = toggle ? 10 : 5;
        he_gap   = toggle ? 12 : 6;
        fl       = 24 + adj;
        k        = 0;
        last_h   = 0;
        for (int c = 0; c < ncyc; c++) begin
            drive(1'b1, toggle ? logic'(c % 2 == 0) : 1'b1, 6'd0, 8'd0);
            check("strobe_without_h", int'({Scanline_End, V_total} & {2{~Horizontal}}), 0);
            if (Horizontal_End) begin
                if (k == 0) check("he_first", c, first_he);
                else        check("he_gap", c - last_h, he_gap);
            end
            if (Horizontal) begin
                kk = k % fl;
                if (k == 0) check("h_first", c, first_h);
                else        check("h_gap", c - last_h, period);
                check("se_at_h", int'(Scanline_End), int'(kk < 24 && kk % 4 == 3));
                check("vt_at_h", int'(V_total), int'(kk == fl - 1));
                check("ra_at_h", int'(RA), (kk < 24) ? kk % 4 : 0);
                last_h = c;
                k++;
            end
        end
        exp_n = (ncyc - 1 - first_h) / period + 1;
        check("h_count", k, exp_n);
    endtask

    function automatic logic [10:0] ev(input logic [3:0] strobes, input logic [4:0] ra, input logic [1:0] win);
        return {strobes, ra, win};
    endfunction

    initial begin : main
        int n, hits, vt_n, vt_hits;
        int r0, r1, r4, r5, r6, r9;

        reset_n = 1'b0; video_clock_enable = 1'b0; internal_data_bus = 8'd0;
        write_horizontal_total_register = 1'b0; write_horizontal_displayed_register = 1'b0;
        write_vertical_total_register = 1'b0; write_vertical_total_adjust_register = 1'b0;
        write_vertical_displayed_register = 1'b0; write_maximum_scan_line_register = 1'b0;

        // all six registers written to 1 at once: 2-char lines, 2 scanlines, 2 rows, 1 adjust line
        vecs[0]  = '{1'b1, 1'b0, 6'h3F, 8'd1, ev(4'b0000, 5'd0, 2'b00)};
        vecs[1]  = '{1'b1, 1'b1, 6'h00, 8'd0, ev(4'b0000, 5'd0, 2'b00)};
        vecs[2]  = '{1'b1, 1'b1, 6'h00, 8'd0, ev(4'b1100, 5'd0, 2'b01)};
        vecs[3]  = '{1'b1, 1'b1, 6'h00, 8'd0, ev(4'b0000, 5'd1, 2'b11)};
        vecs[4]  = '{1'b1, 1'b1, 6'h00, 8'd0, ev(4'b1110, 5'd1, 2'b01)};
        vecs[5]  = '{1'b1, 1'b1, 6'h00, 8'd0, ev(4'b0000, 5'd0, 2'b10)};
        vecs[6]  = '{1'b1, 1'b1, 6'h00, 8'd0, ev(4'b1100, 5'd0, 2'b00)};
        vecs[7]  = '{1'b1, 1'b1, 6'h00, 8'd0, ev(4'b0000, 5'd1, 2'b10)};
        vecs[8]  = '{1'b1, 1'b1, 6'h00, 8'd0, ev(4'b1110, 5'd1, 2'b00)};
        vecs[9]  = '{1'b1, 1'b1, 6'h00, 8'd0, ev(4'b0000, 5'd0, 2'b10)};
        vecs[10] = '{1'b1, 1'b1, 6'h00, 8'd0, ev(4'b1101, 5'd0, 2'b00)};
        vecs[11] = '{1'b1, 1'b0, 6'h00, 8'd0, ev(4'b0000, 5'd0, 2'b11)};
        vecs[12] = '{1'b1, 1'b1, 6'h00, 8'd0, ev(4'b0000, 5'd0, 2'b11)};
        vecs[13] = '{1'b1, 1'b0, 6'h00, 8'd0, ev(4'b0000, 5'd0, 2'b01)};
        vecs[14] = '{1'b1, 1'b1, 6'h00, 8'd0, ev(4'b1100, 5'd0, 2'b01)};

        drive(1'b0, 1'b0, 6'd0, 8'd0);
        check("reset_ra", int'(RA), 0);
        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].rn, vecs[i].ce, vecs[i].wr, vecs[i].d);
            check($sformatf("vec%0d", i),
                  int'({Horizontal, Horizontal_End, Scanline_End, V_total, RA,
                        horizontal_display, vertical_display}),
                  int'(vecs[i].exp));
        end

        // defaults with enable toggling every clock
        drive(1'b0, 1'b0, 6'd0, 8'd0);
        line_events(1'b1, 0, 1100);

        // two adjust lines per frame
        drive(1'b0, 1'b0, 6'd0, 8'd0);
        write_reg(W_R5, 8'd2);
        line_events(1'b0, 2, 600);

        // R0 rewritten below the running count: h_count wraps through 255
        drive(1'b0, 1'b0, 6'd0, 8'd0);
        for (int c = 0; c < 7; c++) drive(1'b1, 1'b1, 6'd0, 8'd0);
        write_reg(W_R0, 8'd3);
        check("wr_cycle_no_h", int'(Horizontal), 0);
        n = -1;
        for (int c = 0; c < 400; c++) begin
            drive(1'b1, 1'b1, 6'd0, 8'd0);
            if (Horizontal) begin n = c; break; end
        end
        check("wrap_h_index", n, 252);
        drive(1'b1, 1'b0, 6'd0, 8'd0);
        check("ra_after_wrap_line", int'(RA), 1);
        n = -1;
        for (int c = 0; c < 20; c++) begin
            drive(1'b1, 1'b1, 6'd0, 8'd0);
            if (Horizontal) begin n = c; break; end
        end
        check("short_line_len", n, 3);

        // narrower windows
        drive(1'b0, 1'b0, 6'd0, 8'd0);
        model_reset();
        write_reg(W_R6, 8'd2); m_r6 = 2;
        write_reg(W_R1, 8'd4); m_r1 = 4;
        run_model(300, 1'b0);

        // reset mid-row with a Horizontal pending and a modified R5
        drive(1'b0, 1'b0, 6'd0, 8'd0);
        write_reg(W_R5, 8'd7);
        for (int c = 0; c < 164; c++) drive(1'b1, 1'b1, 6'd0, 8'd0);
        check("pre_reset_ra", int'(RA), 2);
        drive(1'b0, 1'b1, 6'd0, 8'd0);
        check("strobes_in_reset", int'({Horizontal, Horizontal_End, Scanline_End, V_total}), 0);
        drive(1'b1, 1'b0, 6'd0, 8'd0);
        check("post_reset_state", int'({RA, horizontal_display, vertical_display, display_enable}), 0);
        hits = 0; vt_n = -1; vt_hits = -1;
        for (int c = 0; c < 3000; c++) begin
            drive(1'b1, 1'b1, 6'd0, 8'd0);
            if (Horizontal) hits++;
            if (V_total) begin vt_n = c; vt_hits = hits; break; end
        end
        check("post_reset_vt_cycle", vt_n, 263);
        check("post_reset_vt_lines", vt_hits, 24);

        // randomized geometry and enable pattern against the reference model
        for (int t = 0; t < 8; t++) begin
            drive(1'b0, 1'b0, 6'd0, 8'd0);
            model_reset();
            r0 = int'($urandom_range(0, 12));
            r1 = int'($urandom_range(0, r0 + 1));
            r4 = int'($urandom_range(0, 4));
            r9 = int'($urandom_range(0, 3));
            r5 = int'($urandom_range(0, 3));
            r6 = int'($urandom_range(0, r4 + 2));
            if (t == 0) r1 = 0;
            if (t == 1) r6 = 0;
            if (t == 2) r5 = 0;
            write_reg(W_R0, 8'(r0)); m_r0 = r0;
            write_reg(W_R1, 8'(r1)); m_r1 = r1;
            write_reg(W_R4, 8'(r4)); m_r4 = r4;
            write_reg(W_R5, 8'(r5)); m_r5 = r5;
            write_reg(W_R6, 8'(r6)); m_r6 = r6;
            write_reg(W_R9, 8'(r9)); m_r9 = r9;
            run_model(800, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
